// File: rtl/polyvecl_pointwise_acc_seq.sv
// ---------------------------------------------------------------------------
// polyvecl_pointwise_acc_seq
//
// Computes one result row of the Dilithium pointwise matrix-vector stage:
//    w[n] = sum_{l<L} mont(u[l][n] * v[l][n]),  n < N
// One Montgomery product is issued per cycle through a single 3-stage
// multiplier pipeline. The block answers a level start/done handshake.
//
// Ports
//    clock  in   1        rising-edge clock
//    reset  in   1        asynchronous, active-low reset
//    start  in   1        request level, held by the initiator until done
//    u_in   in   L*N*32   signed polyvecl u, coeff (l,n) at [32*(N*l+n) +: 32]
//    v_in   in   L*N*32   signed polyvecl v, same packing
//    w_out  out  N*32     signed result poly, coeff n at [32*n +: 32]
//    done   out  1        result valid level
//
// Build option
//    POLYVECL_ACC_REDUCE_EN : when defined, the last accumulation step of
//    each coefficient (l == L-1) is passed through reduce32, giving a result
//    in [-6283009, 6283008]. Latency is unchanged. When undefined, the raw
//    accumulated sum is written.
//
// FSM states
//    state | meaning
//    IDLE  | waiting for start; w_out holds the previous result
//    RUN   | issuing one (l,n) product per cycle, l outer, n inner
//    DRAIN | flushing the multiplier pipeline into w
//    DONE  | done=1, w_out stable until start is seen low
// ---------------------------------------------------------------------------
module polyvecl_pointwise_acc_seq #(
   parameter int L    = 5,
   parameter int N    = 256,
   parameter int Q    = 8380417,
   parameter int QINV = 58728449
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [L*N*32-1:0] u_in,
   input  logic [L*N*32-1:0] v_in,
   output logic [N*32-1:0]   w_out,
   output logic              done
);

   localparam int LW = (L > 1) ? $clog2(L) : 1;
   localparam int NW = (N > 1) ? $clog2(N) : 1;
   localparam int IW = (L * N > 1) ? $clog2(L * N) : 1;

   localparam logic        [31:0] QINV_U = 32'(QINV);
   localparam logic signed [63:0] Q64    = 64'(Q);
   localparam logic signed [31:0] Q32    = 32'(Q);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state;
   logic [LW-1:0]   l_idx;
   logic [NW-1:0]   n_idx;
   logic [IW-1:0]   issue_idx;
   logic [1:0]      drain_cnt;

   logic            issue;
   logic            abort;

   // pipeline registers
   logic                  s1_vld;
   logic signed [63:0]    s1_p;
   logic [LW-1:0]         s1_l;
   logic [NW-1:0]         s1_n;

   logic                  s2_vld;
   logic signed [63:0]    s2_p;
   logic signed [31:0]    s2_t;
   logic [LW-1:0]         s2_l;
   logic [NW-1:0]         s2_n;

   logic signed [31:0]    w_mem [N];

   // combinational datapath
   logic signed [31:0]    u_sel;
   logic signed [31:0]    v_sel;
   logic signed [63:0]    prod;
   logic        [31:0]    t_lo;
   logic signed [63:0]    tq;
   logic signed [63:0]    diff;
   logic signed [31:0]    r_val;
   logic signed [31:0]    acc_sum;
   logic signed [31:0]    acc_next;

   assign issue = (state == RUN) && start;
   assign abort = ((state == RUN) || (state == DRAIN)) && !start;

   // Flat issue index times 32 is the bit offset of coefficient (l,n).
   assign u_sel = u_in[{issue_idx, 5'd0} +: 32];
   assign v_sel = v_in[{issue_idx, 5'd0} +: 32];

   assign prod  = 64'(u_sel) * 64'(v_sel);
   assign t_lo  = s1_p[31:0] * QINV_U;
   assign tq    = 64'(s2_t) * Q64;
   assign diff  = s2_p - tq;
   // Low 32 bits of diff are zero by construction of t; the arithmetic shift
   // keeps the sign so r lands in (-Q, Q).
   assign r_val = 32'(diff >>> 32);

`ifdef POLYVECL_ACC_REDUCE_EN
   function automatic logic signed [31:0] reduce32(input logic signed [31:0] a);
      logic signed [31:0] q_est;
      q_est = (a + 32'sd4194304) >>> 23;
      return a - q_est * Q32;
   endfunction
`endif

   always_comb begin
      acc_sum  = (s2_l == '0) ? r_val : w_mem[s2_n] + r_val;
`ifdef POLYVECL_ACC_REDUCE_EN
      acc_next = (s2_l == LW'(L - 1)) ? reduce32(acc_sum) : acc_sum;
`else
      acc_next = acc_sum;
`endif
   end

   // Control FSM. The drain counter is loaded with 3 and DONE is entered when
   // it reaches zero, so done rises L*N+4 edges after the edge that accepted
   // start; the last w write happens two edges before that.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         done      <= 1'b0;
         l_idx     <= '0;
         n_idx     <= '0;
         issue_idx <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= RUN;
                  l_idx     <= '0;
                  n_idx     <= '0;
                  issue_idx <= '0;
               end
            end
            RUN: begin
               if (!start) begin
                  state <= IDLE;
               end else if (issue_idx == IW'(L * N - 1)) begin
                  state     <= DRAIN;
                  drain_cnt <= 2'd3;
               end else begin
                  issue_idx <= issue_idx + IW'(1);
                  if (n_idx == NW'(N - 1)) begin
                     n_idx <= '0;
                     l_idx <= l_idx + LW'(1);
                  end else begin
                     n_idx <= n_idx + NW'(1);
                  end
               end
            end
            DRAIN: begin
               if (!start) begin
                  state <= IDLE;
               end else if (drain_cnt == 2'd0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - 2'd1;
               end
            end
            DONE: begin
               if (!start) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Multiplier pipeline and accumulator. An abort kills in-flight products
   // so nothing from a dropped request lands in w.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_vld <= 1'b0;
         s1_p   <= '0;
         s1_l   <= '0;
         s1_n   <= '0;
         s2_vld <= 1'b0;
         s2_p   <= '0;
         s2_t   <= '0;
         s2_l   <= '0;
         s2_n   <= '0;
         for (int i = 0; i < N; i++) begin
            w_mem[i] <= '0;
         end
      end else begin
         s1_vld <= issue;
         if (issue) begin
            s1_p <= prod;
            s1_l <= l_idx;
            s1_n <= n_idx;
         end

         s2_vld <= s1_vld && !abort;
         if (s1_vld) begin
            s2_p <= s1_p;
            s2_t <= $signed(t_lo);
            s2_l <= s1_l;
            s2_n <= s1_n;
         end

         if (s2_vld && !abort) begin
            w_mem[s2_n] <= acc_next;
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_wout
      assign w_out[32*gi +: 32] = w_mem[gi];
   end

endmodule
